// File: rtl/alu_issue_stage_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : alu_issue_stage_if
// Brief   : Decode-side, forwarding and execute-side signals of the ALU issue stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface alu_issue_stage_if #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5,
   parameter int CTRLW = 4
);
   logic             inValid;
   logic             inReady;
   logic [RADDR-1:0] inRs1Addr;
   logic [RADDR-1:0] inRs2Addr;
   logic [RADDR-1:0] inRdAddr;
   logic [XLEN-1:0]  inRs1Data;
   logic [XLEN-1:0]  inRs2Data;
   logic [XLEN-1:0]  inImm;
   logic [XLEN-1:0]  inPc;
   logic             inUseImm;
   logic             inUsePc;
   logic             inRegWrite;
   logic [CTRLW-1:0] inAluControl;
   logic             flush;
   logic             exMemRegWrite;
   logic [RADDR-1:0] exMemRd;
   logic [XLEN-1:0]  exMemResult;
   logic             memWbRegWrite;
   logic [RADDR-1:0] memWbRd;
   logic [XLEN-1:0]  memWbResult;
   logic             outValid;
   logic             outReady;
   logic [XLEN-1:0]  aluIn1;
   logic [XLEN-1:0]  aluIn2;
   logic [CTRLW-1:0] aluControl;
   logic [XLEN-1:0]  storeData;
   logic [RADDR-1:0] outRd;
   logic             outRegWrite;

   modport master (
      output inValid, inRs1Addr, inRs2Addr, inRdAddr, inRs1Data, inRs2Data,
             inImm, inPc, inUseImm, inUsePc, inRegWrite, inAluControl, flush,
             exMemRegWrite, exMemRd, exMemResult,
             memWbRegWrite, memWbRd, memWbResult, outReady,
      input  inReady, outValid, aluIn1, aluIn2, aluControl, storeData,
             outRd, outRegWrite
   );

   modport slave (
      input  inValid, inRs1Addr, inRs2Addr, inRdAddr, inRs1Data, inRs2Data,
             inImm, inPc, inUseImm, inUsePc, inRegWrite, inAluControl, flush,
             exMemRegWrite, exMemRd, exMemResult,
             memWbRegWrite, memWbRd, memWbResult, outReady,
      output inReady, outValid, aluIn1, aluIn2, aluControl, storeData,
             outRd, outRegWrite
   );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : alu_issue_stage
// Brief   : ID/EX register with valid/ready hold and EX/MEM, MEM/WB forwarding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5,
   parameter int CTRLW = 4
) (
   input  logic               clk,
   input  logic               rstN,
   alu_issue_stage_if.slave   bus
);
   localparam logic [RADDR-1:0] C_X0 = '0;

   logic             r_outValid;
   logic [RADDR-1:0] r_rs1Addr;
   logic [RADDR-1:0] r_rs2Addr;
   logic [RADDR-1:0] r_rdAddr;
   logic [XLEN-1:0]  r_rs1Data;
   logic [XLEN-1:0]  r_rs2Data;
   logic [XLEN-1:0]  r_imm;
   logic [XLEN-1:0]  r_pc;
   logic             r_useImm;
   logic             r_usePc;
   logic             r_regWrite;
   logic [CTRLW-1:0] r_aluControl;

   logic             w_inReady;
   logic             w_capture;
   logic             w_stall;
   logic [XLEN-1:0]  w_fwdRs1;
   logic [XLEN-1:0]  w_fwdRs2;

   assign w_inReady = !r_outValid || bus.outReady;
   assign w_capture = bus.inValid && w_inReady && !bus.flush;
   assign w_stall   = r_outValid && !bus.outReady;

   // EX/MEM is the younger producer, so it takes priority over MEM/WB.
   always_comb begin
      w_fwdRs1 = r_rs1Data;
      if (r_rs1Addr != C_X0 && bus.exMemRegWrite && bus.exMemRd == r_rs1Addr)
         w_fwdRs1 = bus.exMemResult;
      else if (r_rs1Addr != C_X0 && bus.memWbRegWrite && bus.memWbRd == r_rs1Addr)
         w_fwdRs1 = bus.memWbResult;
   end

   always_comb begin
      w_fwdRs2 = r_rs2Data;
      if (r_rs2Addr != C_X0 && bus.exMemRegWrite && bus.exMemRd == r_rs2Addr)
         w_fwdRs2 = bus.exMemResult;
      else if (r_rs2Addr != C_X0 && bus.memWbRegWrite && bus.memWbRd == r_rs2Addr)
         w_fwdRs2 = bus.memWbResult;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_outValid   <= 1'b0;
         r_rs1Addr    <= '0;
         r_rs2Addr    <= '0;
         r_rdAddr     <= '0;
         r_rs1Data    <= '0;
         r_rs2Data    <= '0;
         r_imm        <= '0;
         r_pc         <= '0;
         r_useImm     <= 1'b0;
         r_usePc      <= 1'b0;
         r_regWrite   <= 1'b0;
         r_aluControl <= '0;
      end else begin
         if (bus.flush) begin
            r_outValid <= 1'b0;
         end else if (w_capture) begin
            r_outValid <= 1'b1;
         end else if (bus.outReady) begin
            r_outValid <= 1'b0;
         end

         if (w_capture) begin
            r_rs1Addr    <= bus.inRs1Addr;
            r_rs2Addr    <= bus.inRs2Addr;
            r_rdAddr     <= bus.inRdAddr;
            r_rs1Data    <= bus.inRs1Data;
            r_rs2Data    <= bus.inRs2Data;
            r_imm        <= bus.inImm;
            r_pc         <= bus.inPc;
            r_useImm     <= bus.inUseImm;
            r_usePc      <= bus.inUsePc;
            r_regWrite   <= bus.inRegWrite;
            r_aluControl <= bus.inAluControl;
         end else if (w_stall) begin
            // A write-back retiring during the stall would otherwise vanish.
            if (r_rs1Addr != C_X0 && bus.memWbRegWrite && bus.memWbRd == r_rs1Addr)
               r_rs1Data <= bus.memWbResult;
            if (r_rs2Addr != C_X0 && bus.memWbRegWrite && bus.memWbRd == r_rs2Addr)
               r_rs2Data <= bus.memWbResult;
         end
      end
   end

   assign bus.inReady     = w_inReady;
   assign bus.outValid    = r_outValid;
   assign bus.aluIn1      = r_usePc  ? r_pc  : w_fwdRs1;
   assign bus.aluIn2      = r_useImm ? r_imm : w_fwdRs2;
   assign bus.aluControl  = r_aluControl;
   assign bus.storeData   = w_fwdRs2;
   assign bus.outRd       = r_rdAddr;
   assign bus.outRegWrite = r_regWrite && r_outValid;
endmodule
`default_nettype wire
